// File: rtl/axi_w_snoop_streamer.sv
// -----------------------------------------------------------------------------
// axi_w_snoop_streamer
//
// Sits on the AXI write-data (W) channel. Every beat is forwarded from the
// slave side to the master side with zero latency, and every accepted beat is
// also captured ({wlast, wdata}) into a small FIFO. The captured bursts are
// then offered to the shared stream arbiter one whole burst at a time:
// in_progress holds the stream for the full burst, across arbiter stalls and
// across gaps where the FIFO runs dry in the middle of a burst.
//
// Ports
//   clk, resetn              clock (rising edge), async active-low reset
//   ready                    arbiter accepts the current stream beat
//   valid                    a stream beat is available
//   in_progress              this block owns the stream
//   data, data_last          head beat of the capture FIFO (0 when empty)
//   AXIS_w*                  AXI W slave-side inputs, AXIS_wready output
//   AXIM_w*                  AXI W master-side outputs, AXIM_wready input
// -----------------------------------------------------------------------------
module axi_w_snoop_streamer #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 32,
  parameter int USER_WIDTH = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    resetn,
  // stream side
  input  logic                    ready,
  output logic                    valid,
  output logic                    in_progress,
  output logic [DATA_WIDTH-1:0]   data,
  output logic                    data_last,
  // AXI W slave side
  input  logic [ID_WIDTH-1:0]     AXIS_wid,
  input  logic [DATA_WIDTH-1:0]   AXIS_wdata,
  input  logic [DATA_WIDTH/8-1:0] AXIS_wstrb,
  input  logic                    AXIS_wlast,
  input  logic [USER_WIDTH-1:0]   AXIS_wuser,
  input  logic                    AXIS_wvalid,
  output logic                    AXIS_wready,
  // AXI W master side
  output logic [ID_WIDTH-1:0]     AXIM_wid,
  output logic [DATA_WIDTH-1:0]   AXIM_wdata,
  output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
  output logic                    AXIM_wlast,
  output logic [USER_WIDTH-1:0]   AXIM_wuser,
  output logic                    AXIM_wvalid,
  input  logic                    AXIM_wready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                state, state_nxt;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]  bursts;

  logic                  full, empty;
  logic                  cap, pop;
  logic [DATA_WIDTH:0]   head;
  logic                  head_last;

  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // ---- passthrough (combinational) ----
  assign AXIM_wid    = AXIS_wid;
  assign AXIM_wdata  = AXIS_wdata;
  assign AXIM_wstrb  = AXIS_wstrb;
  assign AXIM_wlast  = AXIS_wlast;
  assign AXIM_wuser  = AXIS_wuser;
  // A full FIFO stalls the W channel in both directions so no beat can slip
  // past without being captured.
  assign AXIM_wvalid = AXIS_wvalid & ~full;
  assign AXIS_wready = AXIM_wready & ~full;

  assign cap = AXIS_wvalid & AXIS_wready;

  // ---- capture FIFO storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (cap) begin
      mem[wr_ptr[PTR_W-1:0]] <= {AXIS_wlast, AXIS_wdata};
    end
  end

  // First-word fall-through head; outputs read 0 while the FIFO is empty.
  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign head_last = head[DATA_WIDTH];
  assign data      = empty ? '0 : head[DATA_WIDTH-1:0];
  assign data_last = ~empty & head_last;

  // ---- stream FSM: next state and handshake outputs ----
  always_comb begin
    state_nxt   = state;
    valid       = 1'b0;
    in_progress = 1'b0;
    case (state)
      IDLE: begin
        // A full FIFO releases a burst early so bursts longer than the FIFO
        // cannot deadlock the W channel.
        valid = (bursts != '0) | full;
        if (valid & ready) begin
          in_progress = 1'b1;
          if (!head_last) begin
            state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        valid       = ~empty;
        in_progress = 1'b1;
        if (valid & ready & head_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign pop = valid & ready;

  // ---- control registers: state, pointers, burst count ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      bursts <= '0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A completed burst arriving while another completes leaving cancels.
      case ({cap & AXIS_wlast, pop & head_last})
        2'b10:   bursts <= bursts + CNT_WIDTH'(1);
        2'b01:   bursts <= bursts - CNT_WIDTH'(1);
        default: bursts <= bursts;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_w_snoop_streamer.sv
// -----------------------------------------------------------------------------
// Testbench for axi_w_snoop_streamer. A queue-based reference model tracks the
// captured beats; every clock the handshake, head data and passthrough
// outputs are compared against it, plus directed checks for each scenario.
// -----------------------------------------------------------------------------
module tb_axi_w_snoop_streamer;

  localparam int DW    = 32;
  localparam int IW    = 8;
  localparam int UW    = 8;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ready;
  logic          valid;
  logic          in_progress;
  logic [DW-1:0] data;
  logic          data_last;
  logic [IW-1:0] AXIS_wid;
  logic [DW-1:0] AXIS_wdata;
  logic [SW-1:0] AXIS_wstrb;
  logic          AXIS_wlast;
  logic [UW-1:0] AXIS_wuser;
  logic          AXIS_wvalid;
  logic          AXIS_wready;
  logic [IW-1:0] AXIM_wid;
  logic [DW-1:0] AXIM_wdata;
  logic [SW-1:0] AXIM_wstrb;
  logic          AXIM_wlast;
  logic [UW-1:0] AXIM_wuser;
  logic          AXIM_wvalid;
  logic          AXIM_wready;

  axi_w_snoop_streamer #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW),
    .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .ready(ready), .valid(valid), .in_progress(in_progress),
    .data(data), .data_last(data_last),
    .AXIS_wid(AXIS_wid), .AXIS_wdata(AXIS_wdata), .AXIS_wstrb(AXIS_wstrb),
    .AXIS_wlast(AXIS_wlast), .AXIS_wuser(AXIS_wuser),
    .AXIS_wvalid(AXIS_wvalid), .AXIS_wready(AXIS_wready),
    .AXIM_wid(AXIM_wid), .AXIM_wdata(AXIM_wdata), .AXIM_wstrb(AXIM_wstrb),
    .AXIM_wlast(AXIM_wlast), .AXIM_wuser(AXIM_wuser),
    .AXIM_wvalid(AXIM_wvalid), .AXIM_wready(AXIM_wready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [DW:0] q[$];
  int          m_bursts;
  bit          m_stream;
  bit          capped;
  int          pops;
  int          ip_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_bursts = 0;
    m_stream = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, return 1 time unit later so the caller can drive inputs.
  task automatic tick();
    logic        exp_full, exp_empty, exp_valid, exp_pop, exp_cap, exp_swready;
    logic [DW:0] head, pv;
    @(negedge clk);
    exp_full    = (q.size() == DEPTH);
    exp_empty   = (q.size() == 0);
    exp_valid   = m_stream ? !exp_empty : ((m_bursts != 0) || exp_full);
    exp_pop     = exp_valid & ready;
    head        = exp_empty ? '0 : q[0];
    exp_swready = AXIM_wready & !exp_full;
    exp_cap     = AXIS_wvalid & exp_swready;
    if (in_progress === 1'b1) ip_cnt++;
    chk("valid", 64'(valid), 64'(exp_valid));
    chk("in_progress", 64'(in_progress), 64'(m_stream | exp_pop));
    chk("data", 64'(data), 64'(head[DW-1:0]));
    chk("data_last", 64'(data_last), 64'(head[DW]));
    chk("AXIS_wready", 64'(AXIS_wready), 64'(exp_swready));
    chk("AXIM_wvalid", 64'(AXIM_wvalid), 64'(AXIS_wvalid & !exp_full));
    chk("AXIM_wdata", 64'(AXIM_wdata), 64'(AXIS_wdata));
    chk("AXIM_w_side", 64'({AXIM_wid, AXIM_wstrb, AXIM_wlast, AXIM_wuser}),
        64'({AXIS_wid, AXIS_wstrb, AXIS_wlast, AXIS_wuser}));
    @(posedge clk);
    capped = 1'b0;
    if (resetn) begin
      if (exp_pop) begin
        pv = q.pop_front();
        pops++;
        if (pv[DW]) begin
          m_bursts--;
          m_stream = 1'b0;
        end else begin
          m_stream = 1'b1;
        end
      end
      if (exp_cap) begin
        q.push_back({AXIS_wlast, AXIS_wdata});
        capped = 1'b1;
        if (AXIS_wlast) m_bursts++;
      end
    end
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n;
    AXIS_wvalid = 1'b1;
    AXIS_wdata  = d;
    AXIS_wlast  = l;
    AXIS_wid    = IW'($urandom);
    AXIS_wstrb  = SW'($urandom);
    AXIS_wuser  = UW'($urandom);
    n = 0;
    capped = 1'b0;
    while (!capped && n < 100) begin
      tick();
      n++;
    end
    chk("send_beat_captured", 64'(capped), 64'(1));
  endtask

  task automatic idle_n(input int n);
    AXIS_wvalid = 1'b0;
    AXIS_wlast  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n;
    ready       = 1'b1;
    AXIS_wvalid = 1'b0;
    AXIS_wlast  = 1'b0;
    n = 0;
    while ((q.size() != 0 || m_stream) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(n < 200), 64'(1));
    tick();
  endtask

  initial begin
    int n;
    resetn = 1'b0; ready = 1'b0; AXIM_wready = 1'b1;
    AXIS_wid = '0; AXIS_wdata = '0; AXIS_wstrb = '0; AXIS_wlast = 1'b0;
    AXIS_wuser = '0; AXIS_wvalid = 1'b0;
    pops = 0; ip_cnt = 0; capped = 1'b0;
    model_reset();

    // 1: reset state
    #12;
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_in_progress", 64'(in_progress), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_data_last", 64'(data_last), 64'(0));
    chk("rst_AXIS_wready", 64'(AXIS_wready), 64'(1));
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();

    // 2: single 4-beat burst, arbiter always ready
    ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(DW'(32'hA0 + i), i == 3);
    chk("t2_valid_after_wlast", 64'(valid), 64'(1));
    chk("t2_first_data", 64'(data), 64'(32'hA0));
    ip_cnt = 0;
    idle_n(6);
    chk("t2_in_progress_cycles", 64'(ip_cnt), 64'(4));

    // 3: arbiter stalls for 3 clocks after the 2nd streamed beat
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(DW'(32'hA0 + i), i == 3);
    AXIS_wvalid = 1'b0; AXIS_wlast = 1'b0;
    ready = 1'b1;
    pops = 0; n = 0;
    while (pops < 2 && n < 20) begin tick(); n++; end
    ready = 1'b0;
    idle_n(3);
    chk("t3_hold_data", 64'(data), 64'(32'hA2));
    chk("t3_hold_in_progress", 64'(in_progress), 64'(1));
    ready = 1'b1;
    ip_cnt = 0;
    idle_n(4);
    chk("t3_resume_ip_cycles", 64'(ip_cnt), 64'(2));

    // 4: two 8-beat bursts fill the FIFO, third burst blocked until drain
    ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) send_beat(DW'(32'hC0 + b * 8 + i), i == 7);
    AXIS_wvalid = 1'b1; AXIS_wdata = DW'(32'hD0); AXIS_wlast = 1'b0;
    #1;
    chk("t4_full_AXIS_wready", 64'(AXIS_wready), 64'(0));
    chk("t4_full_AXIM_wvalid", 64'(AXIM_wvalid), 64'(0));
    repeat (3) tick();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(DW'(32'hD0 + i), i == 3);
    drain();

    // 5: 20-beat burst, early release at full
    ready = 1'b0;
    for (int i = 0; i < 16; i++) send_beat(DW'(32'hE0 + i), 1'b0);
    chk("t5_valid_at_full", 64'(valid), 64'(1));
    chk("t5_AXIS_wready_full", 64'(AXIS_wready), 64'(0));
    ready = 1'b1;
    for (int i = 16; i < 20; i++) send_beat(DW'(32'hE0 + i), i == 19);
    drain();

    // 6a: wlast capture coincides with last-beat pop of the prior burst
    ready = 1'b0;
    send_beat(DW'(32'hF0), 1'b0);
    send_beat(DW'(32'hF1), 1'b1);
    AXIS_wvalid = 1'b0; AXIS_wlast = 1'b0;
    ready = 1'b1;
    tick();
    AXIS_wvalid = 1'b1; AXIS_wdata = DW'(32'hF8); AXIS_wlast = 1'b1;
    tick();
    AXIS_wvalid = 1'b0; AXIS_wlast = 1'b0;
    #1;
    chk("t6_valid_after_coincide", 64'(valid), 64'(1));
    chk("t6_data_after_coincide", 64'(data), 64'(32'hF8));
    chk("t6_last_after_coincide", 64'(data_last), 64'(1));
    tick();

    // 6b: reset in the middle of a streaming burst
    ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(DW'(32'h90 + i), i == 3);
    AXIS_wvalid = 1'b0; AXIS_wlast = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(valid), 64'(0));
    chk("t6_rst_in_progress", 64'(in_progress), 64'(0));
    chk("t6_rst_data", 64'(data), 64'(0));
    chk("t6_rst_data_last", 64'(data_last), 64'(0));
    chk("t6_rst_AXIS_wready", 64'(AXIS_wready), 64'(1));
    model_reset();
    tick();
    resetn = 1'b1;
    idle_n(2);
    chk("t6_post_rst_valid", 64'(valid), 64'(0));
    send_beat(DW'(32'h55), 1'b1);
    idle_n(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
